// File: rtl/ball_plate_renderer_pkg.sv
// rtl/ball_plate_renderer_pkg.sv - shared colours, latency and screen constants for the plate renderer
package ball_plate_renderer_pkg;

  localparam logic [11:0] COL_BALL   = 12'hF80;
  localparam logic [11:0] COL_XHAIR  = 12'h0F0;
  localparam logic [11:0] COL_BORDER = 12'hFFF;
  localparam logic [11:0] COL_PLATE  = 12'h444;
  localparam logic [11:0] COL_BLACK  = 12'h000;

  localparam int PIPE_LAT = 3;
  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;

  typedef struct packed {
    logic blank;
    logic on_screen;
    logic plate;
    logic border;
    logic xhair;
  } flags_t;

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - N-stage shift of {hsync,vsync,blank}, resets to the idle level of all three
module sync_delay #(
  parameter int N = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] d_i,
  output logic [2:0] q_o
);

  logic [2:0] sh_q [N];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) sh_q[i] <= 3'b111;
    end else begin
      sh_q[0] <= d_i;
      for (int i = 1; i < N; i++) sh_q[i] <= sh_q[i-1];
    end
  end

  assign q_o = sh_q[N-1];

endmodule

// File: rtl/ball_plate_renderer.sv
// rtl/ball_plate_renderer.sv - 3-stage pixel pipeline drawing plate, border, crosshair and ball
module ball_plate_renderer
  import ball_plate_renderer_pkg::*;
#(
  parameter int BALL_R   = 16,
  parameter int PLATE_X0 = 128,
  parameter int PLATE_Y0 = 0,
  parameter int PLATE_W  = 768,
  parameter int PLATE_H  = 768,
  parameter int BORDER   = 4,
  parameter int XHAIR_L  = 8
) (
  input  logic        vclock,
  input  logic        reset_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic [10:0] ball_x,
  input  logic [9:0]  ball_y,
  input  logic [10:0] tgt_x,
  input  logic [9:0]  tgt_y,
  input  logic        pos_valid,
  output logic        pix_hsync,
  output logic        pix_vsync,
  output logic        pix_blank,
  output logic [11:0] pix_rgb,
  output logic        frame_start
);

  localparam logic [10:0] CX   = 11'(PLATE_X0 + PLATE_W / 2);
  localparam logic [9:0]  CY   = 10'(PLATE_Y0 + PLATE_H / 2);
  localparam logic [11:0] PX0  = 12'(PLATE_X0);
  localparam logic [11:0] PW   = 12'(PLATE_W);
  localparam logic [11:0] PBX  = 12'(BORDER);
  localparam logic [11:0] PWB  = 12'(PLATE_W - BORDER);
  localparam logic [10:0] PY0  = 11'(PLATE_Y0);
  localparam logic [10:0] PH   = 11'(PLATE_H);
  localparam logic [10:0] PBY  = 11'(BORDER);
  localparam logic [10:0] PHB  = 11'(PLATE_H - BORDER);
  localparam logic [10:0] SW   = 11'(SCREEN_W);
  localparam logic [9:0]  SH   = 10'(SCREEN_H);
  localparam logic signed [11:0] XL = 12'(XHAIR_L);
  localparam logic [24:0] R2   = 25'(BALL_R * BALL_R);

  logic        vsync_q, frame_start_q, boundary;
  logic [10:0] pend_bx_q, pend_tx_q, act_bx_q, act_tx_q;
  logic [9:0]  pend_by_q, pend_ty_q, act_by_q, act_ty_q;

  logic signed [11:0] dx_d, dy_d, dx_q, dy_q, tdx, tdy;
  logic [11:0] px;
  logic [10:0] py;
  flags_t      flags_d, flags1_q, flags2_q;
  logic signed [23:0] dxw, dyw;
  logic [23:0] dx2_d, dy2_d, dx2_q, dy2_q;
  logic [24:0] sum_d;
  logic [11:0] rgb_d, rgb_q;

  // A falling vsync edge marks the frame boundary; pending positions become active there.
  assign boundary = vsync_q & ~vsync;

  always_comb begin
    px = {1'b0, hcount} - PX0;
    py = {1'b0, vcount} - PY0;
    dx_d = $signed({1'b0, hcount}) - $signed({1'b0, act_bx_q});
    dy_d = $signed({2'b00, vcount}) - $signed({2'b00, act_by_q});
    tdx  = $signed({1'b0, hcount}) - $signed({1'b0, act_tx_q});
    tdy  = $signed({2'b00, vcount}) - $signed({2'b00, act_ty_q});
    flags_d.blank     = blank;
    flags_d.on_screen = (hcount < SW) && (vcount < SH);
    flags_d.plate     = (px < PW) && (py < PH);
    flags_d.border    = flags_d.plate && ((px < PBX) || (px >= PWB) || (py < PBY) || (py >= PHB));
    flags_d.xhair     = ((tdx >= -XL) && (tdx <= XL) && (tdy == 12'sd0)) ||
                        ((tdy >= -XL) && (tdy <= XL) && (tdx == 12'sd0));
  end

  always_comb begin
    dxw   = 24'(dx_q);
    dyw   = 24'(dy_q);
    dx2_d = dxw * dxw;
    dy2_d = dyw * dyw;
  end

  always_comb begin
    sum_d = {1'b0, dx2_q} + {1'b0, dy2_q};
    rgb_d = COL_BLACK;
    if (flags2_q.blank)                         rgb_d = COL_BLACK;
    else if ((sum_d <= R2) && flags2_q.on_screen) rgb_d = COL_BALL;
    else if (flags2_q.xhair)                    rgb_d = COL_XHAIR;
    else if (flags2_q.border)                   rgb_d = COL_BORDER;
    else if (flags2_q.plate)                    rgb_d = COL_PLATE;
  end

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
      pend_bx_q     <= CX;
      pend_by_q     <= CY;
      pend_tx_q     <= CX;
      pend_ty_q     <= CY;
      act_bx_q      <= CX;
      act_by_q      <= CY;
      act_tx_q      <= CX;
      act_ty_q      <= CY;
      dx_q          <= '0;
      dy_q          <= '0;
      flags1_q      <= '{blank: 1'b1, default: 1'b0};
      dx2_q         <= '0;
      dy2_q         <= '0;
      flags2_q      <= '{blank: 1'b1, default: 1'b0};
      rgb_q         <= '0;
    end else begin
      vsync_q       <= vsync;
      frame_start_q <= boundary;
      if (pos_valid) begin
        pend_bx_q <= ball_x;
        pend_by_q <= ball_y;
        pend_tx_q <= tgt_x;
        pend_ty_q <= tgt_y;
      end
      // Reads the old pending value, so a strobe on the boundary lands one frame later.
      if (boundary) begin
        act_bx_q <= pend_bx_q;
        act_by_q <= pend_by_q;
        act_tx_q <= pend_tx_q;
        act_ty_q <= pend_ty_q;
      end
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      flags1_q <= flags_d;
      dx2_q    <= dx2_d;
      dy2_q    <= dy2_d;
      flags2_q <= flags1_q;
      rgb_q    <= rgb_d;
    end
  end

  sync_delay #(.N(PIPE_LAT)) u_sync_delay (
    .clk_i  (vclock),
    .rst_ni (reset_n),
    .d_i    ({hsync, vsync, blank}),
    .q_o    ({pix_hsync, pix_vsync, pix_blank})
  );

  assign pix_rgb     = rgb_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ball_plate_renderer.sv
// tb/tb_ball_plate_renderer.sv - directed scoreboard bench for ball_plate_renderer
module tb_ball_plate_renderer;

  logic        vclock = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        hsync = 1'b1, vsync = 1'b1, blank = 1'b1;
  logic [10:0] ball_x = '0, tgt_x = '0;
  logic [9:0]  ball_y = '0, tgt_y = '0;
  logic        pos_valid = 1'b0;
  logic        pix_hsync, pix_vsync, pix_blank, frame_start;
  logic [11:0] pix_rgb;

  ball_plate_renderer dut (
    .vclock(vclock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank),
    .ball_x(ball_x), .ball_y(ball_y), .tgt_x(tgt_x), .tgt_y(tgt_y),
    .pos_valid(pos_valid), .pix_hsync(pix_hsync), .pix_vsync(pix_vsync),
    .pix_blank(pix_blank), .pix_rgb(pix_rgb), .frame_start(frame_start)
  );

  always #5 vclock = ~vclock;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic [2:0]  sync;
    logic [11:0] rgb;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int abx, aby, atx, aty, pbx, pby, ptx, pty;
  bit prev_vs;
  int fs_seen;

  function automatic logic [11:0] model_rgb(input int h, input int v, input bit bl);
    int dx, dy, tx, ty;
    bit inplate;
    dx = h - abx; dy = v - aby;
    tx = h - atx; ty = v - aty;
    if (tx < 0) tx = -tx;
    if (ty < 0) ty = -ty;
    inplate = (h >= 128) && (h < 896) && (v >= 0) && (v < 768);
    if (bl) return 12'h000;
    if (dx * dx + dy * dy <= 256) return 12'hF80;
    if ((tx <= 8 && v == aty) || (ty <= 8 && h == atx)) return 12'h0F0;
    if (inplate && (h < 132 || h >= 892 || v < 4 || v >= 764)) return 12'hFFF;
    if (inplate) return 12'h444;
    return 12'h000;
  endfunction

  task automatic model_reset();
    pbx = 512; pby = 384; ptx = 512; pty = 384;
    abx = 512; aby = 384; atx = 512; aty = 384;
    prev_vs = 1'b1;
  endtask

  task automatic set_pos(input int bx, input int by, input int tx, input int ty);
    ball_x = 11'(bx); ball_y = 10'(by); tgt_x = 11'(tx); tgt_y = 10'(ty);
  endtask

  task automatic drive(input int h, input int v, input bit pv, input bit use_c, input logic [11:0] c);
    bit hs, vs, bl, bnd;
    exp_t e;
    hs = !(h >= 1048 && h < 1184);
    vs = !(v >= 771 && v < 777);
    bl = (h >= 1024) || (v >= 768);
    hcount = 11'(h); vcount = 10'(v);
    hsync = hs; vsync = vs; blank = bl; pos_valid = pv;
    e.h = 11'(h); e.v = 10'(v); e.sync = {hs, vs, bl};
    e.rgb = use_c ? c : model_rgb(h, v, bl);
    q.push_back(e);
    bnd = prev_vs && !vs;
    if (bnd) begin abx = pbx; aby = pby; atx = ptx; aty = pty; end
    if (pv) begin pbx = int'(ball_x); pby = int'(ball_y); ptx = int'(tgt_x); pty = int'(tgt_y); end
    prev_vs = vs;
    @(posedge vclock); #1;
    pos_valid = 1'b0;
    total++;
    assert (frame_start === bnd) else begin
      bad++; $error("FAIL frame_start at h=%0d v=%0d observed=%b expected=%b", h, v, frame_start, bnd);
    end
    if (frame_start === 1'b1) fs_seen++;
    if (q.size() == 3) begin
      e = q.pop_front();
      total++;
      assert ({pix_hsync, pix_vsync, pix_blank} === e.sync) else begin
        bad++; $error("FAIL sync h=%0d v=%0d observed=%b expected=%b", e.h, e.v, {pix_hsync, pix_vsync, pix_blank}, e.sync);
      end
      total++;
      assert (pix_rgb === e.rgb) else begin
        bad++; $error("FAIL rgb h=%0d v=%0d observed=%h expected=%h", e.h, e.v, pix_rgb, e.rgb);
      end
    end
  endtask

  task automatic probe(input int h, input int v, input logic [11:0] c);
    drive(h, v, 1'b0, 1'b1, c);
  endtask

  task automatic scan(input int h0, input int h1, input int v0, input int v1);
    for (int v = v0; v <= v1; v++)
      for (int h = h0; h <= h1; h++) drive(h, v, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic gap(input bit pv_on_boundary);
    fs_seen = 0;
    for (int v = 769; v <= 778; v++)
      for (int h = 1024; h <= 1031; h++)
        drive(h, v, pv_on_boundary && v == 771 && h == 1024, 1'b0, 12'h000);
    total++;
    assert (fs_seen == 1) else begin
      bad++; $error("FAIL frame_start_count observed=%0d expected=1", fs_seen);
    end
  endtask

  task automatic do_reset(input int h, input int v);
    hcount = 11'(h); vcount = 10'(v);
    hsync = 1'b1; vsync = 1'b1; blank = 1'b0; pos_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge vclock); #1;
    total++;
    assert ({pix_hsync, pix_vsync, pix_blank} === 3'b111) else begin
      bad++; $error("FAIL reset_sync observed=%b expected=111", {pix_hsync, pix_vsync, pix_blank});
    end
    total++;
    assert (pix_rgb === 12'h000) else begin
      bad++; $error("FAIL reset_rgb observed=%h expected=000", pix_rgb);
    end
    total++;
    assert (frame_start === 1'b0) else begin
      bad++; $error("FAIL reset_frame_start observed=%b expected=0", frame_start);
    end
    @(posedge vclock); #1;
    reset_n = 1'b1;
    q.delete();
    model_reset();
  endtask

  initial begin
    model_reset();
    set_pos(512, 384, 512, 384);
    do_reset(0, 0);

    // Frame after reset: centre ball, plate edges, border and hsync window
    probe(512, 368, 12'hF80); probe(528, 384, 12'hF80);
    probe(529, 384, 12'h444); probe(512, 367, 12'h444);
    probe(496, 384, 12'hF80); probe(512, 400, 12'hF80); probe(512, 401, 12'h444);
    probe(128, 100, 12'hFFF); probe(131, 100, 12'hFFF); probe(132, 100, 12'h444);
    probe(127, 100, 12'h000); probe(895, 100, 12'hFFF); probe(896, 100, 12'h000);
    probe(300, 3, 12'hFFF); probe(300, 4, 12'h444); probe(300, 767, 12'hFFF);
    scan(126, 134, 0, 5);
    scan(888, 900, 760, 770);
    scan(1018, 1190, 100, 100);

    // Mid-frame update only takes effect after the next boundary
    set_pos(300, 300, 600, 500);
    drive(700, 100, 1'b1, 1'b0, 12'h000);
    probe(512, 384, 12'hF80); probe(300, 300, 12'h444);
    gap(1'b0);
    probe(300, 300, 12'hF80); probe(300, 284, 12'hF80); probe(300, 283, 12'h444);
    probe(316, 300, 12'hF80); probe(317, 300, 12'h444); probe(512, 384, 12'h444);
    probe(600, 500, 12'h0F0); probe(608, 500, 12'h0F0); probe(609, 500, 12'h444);
    probe(600, 492, 12'h0F0); probe(600, 491, 12'h444); probe(601, 501, 12'h444);
    scan(590, 610, 498, 502);

    // Strobe on the boundary cycle lands one frame late
    set_pos(700, 200, 600, 500);
    drive(800, 600, 1'b1, 1'b0, 12'h000);
    probe(300, 300, 12'hF80);
    set_pos(400, 600, 600, 500);
    gap(1'b1);
    probe(700, 200, 12'hF80); probe(400, 600, 12'h444);
    gap(1'b0);
    probe(400, 600, 12'hF80); probe(700, 200, 12'h444);

    // Ball in the top-left corner, crosshair at centre
    set_pos(5, 5, 512, 384);
    drive(1030, 300, 1'b1, 1'b0, 12'h000);
    gap(1'b0);
    scan(0, 25, 0, 22);
    probe(0, 0, 12'hF80); probe(5, 20, 12'hF80); probe(5, 21, 12'hF80);
    probe(5, 22, 12'h000); probe(21, 5, 12'hF80); probe(22, 5, 12'h000);
    scan(1010, 1023, 0, 12);
    scan(0, 30, 755, 767);
    probe(1023, 767, 12'h000); probe(1023, 0, 12'h000);
    probe(504, 384, 12'h0F0); probe(503, 384, 12'h444);
    probe(512, 392, 12'h0F0); probe(512, 393, 12'h444);

    // Reset mid-frame, then rendering restarts from the plate centre
    probe(600, 399, 12'h444); probe(600, 399, 12'h444);
    do_reset(600, 400);
    probe(512, 384, 12'hF80); probe(512, 368, 12'hF80);
    probe(5, 5, 12'h000); probe(600, 400, 12'h444);
    gap(1'b0);
    probe(512, 384, 12'hF80); probe(5, 5, 12'h000);
    for (int i = 0; i < 3; i++) drive(1030, 770, 1'b0, 1'b0, 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
